mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. Turns load/store control from EX/MEM into a req/ack transaction on a variable-latency data-memory port, stalls upstream stages until the access completes, and aligns and extends load data. Its outputs drive the MEM/WB register inputs directly.

---
 rtl/mem_access_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory-access stage sitting between the EX/MEM and MEM/WB registers.
// Turns load/store control into one req/ack transaction on a
// variable-latency data-memory port, stalls the upstream stages while the
// access is outstanding, and aligns/extends load data for write-back.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that sees no
// ack within TIMEOUT_CYCLES cycles in ACCESS (bus_err pulses in DONE).
// Without it ACCESS waits indefinitely and bus_err is tied 0.
//
// Bus handshake: dmem_req rises the cycle after an access is accepted and
// stays high with dmem_we/addr/wdata/be stable until the first cycle in
// which dmem_ack is sampled high in ACCESS; acks seen in IDLE or DONE are
// ignored.
//
// Ports:
//   clock, reset_n          clock (rising edge), synchronous active-low reset
//   alu_result_in           byte address, also passed through
//   store_data_in           store source value
//   reg_dest_in             destination register
//   MemRead_in/MemWrite_in  load / store request
//   MemToReg_in/RegWrite_in write-back control
//   MemSize_in              00 byte, 01 half, 10 word, 11 illegal
//   MemSigned_in            sign-extend (1) or zero-extend (0) loads
//   dmem_*                  data-memory port
//   stall                   freezes PC, IF/ID, ID/EX, EX/MEM
//   mem_data_out            aligned load data (valid in DONE, else 0)
//   alu_result_out, reg_dest_out, MemToReg_out, RegWrite_out  to MEM/WB
//   misalign_err            pulse on misaligned/illegal access
//   bus_err                 pulse on bus timeout
//   state_dbg               current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  reg_dest_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemSigned_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  reg_dest_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] data_q, data_d;
  // Load shaping info captured at accept time, used when the ack arrives.
  logic [1:0]  lsize_q, lsize_d;
  logic [1:0]  lane_q, lane_d;
  logic        lsigned_q, lsigned_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic        any_op, bad_op, in_idle, start;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Access legality is judged only in IDLE, on the live EX/MEM inputs.
  assign any_op  = MemRead_in | MemWrite_in;
  assign bad_op  = (MemRead_in & MemWrite_in)
                 | (MemSize_in == 2'b11)
                 | ((MemSize_in == 2'b01) & alu_result_in[0])
                 | ((MemSize_in == 2'b10) & (alu_result_in[1:0] != 2'b00));
  assign in_idle = (state_q == S_IDLE);
  assign start   = reset_n & in_idle & any_op & ~bad_op;

  // Store lane replication and byte enables (little-endian).
  always_comb begin
    st_wdata = store_data_in;
    st_be    = 4'b1111;
    case (MemSize_in)
      2'b00: begin
        st_wdata = {4{store_data_in[7:0]}};
        st_be    = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data_in[15:0]}};
        st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane selection and extension from the raw bus word.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lsize_q)
      2'b00:   ld_data = {{24{lsigned_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{lsigned_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    data_d    = data_q;
    lsize_d   = lsize_q;
    lane_d    = lane_q;
    lsigned_d = lsigned_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACCESS;
          req_d     = 1'b1;
          we_d      = MemWrite_in;
          addr_d    = {alu_result_in[31:2], 2'b00};
          wdata_d   = MemWrite_in ? st_wdata : 32'h0;
          be_d      = MemWrite_in ? st_be : 4'b1111;
          data_d    = 32'h0;
          lsize_d   = MemSize_in;
          lane_d    = alu_result_in[1:0];
          lsigned_d = MemSigned_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_ACCESS: begin
        // Ack takes priority over the timeout limit on the same cycle.
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          data_d  = we_q ? 32'h0 : ld_data;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          data_d    = 32'h0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      data_q    <= 32'h0;
      lsize_q   <= 2'b00;
      lane_q    <= 2'b00;
      lsigned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      data_q    <= data_d;
      lsize_q   <= lsize_d;
      lane_q    <= lane_d;
      lsigned_q <= lsigned_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign state_dbg      = state_q;

  assign misalign_err   = reset_n & in_idle & any_op & bad_op;
  assign stall          = reset_n & (start | (state_q == S_ACCESS));
  assign mem_data_out   = (state_q == S_DONE) ? data_q : 32'h0;
  assign alu_result_out = alu_result_in;
  assign reg_dest_out   = reg_dest_in;
  assign MemToReg_out   = MemToReg_in;
  assign RegWrite_out   = RegWrite_in & reset_n & ~misalign_err & ~bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed load/store/illegal vectors with
// hand-computed expectations pushed into scoreboard queues; a negedge
// monitor pops and compares bus requests and pipeline-advance results.
module tb_mem_access_stage;

  localparam int RW = 43;  // {mem_data_out, RegWrite_out, misalign_err, bus_err, stall_cycles[7:0]}
  localparam int BW = 69;  // {dmem_we, dmem_addr, dmem_wdata, dmem_be}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [31:0] alu_result_in, store_data_in, dmem_rdata;
  logic [4:0]  reg_dest_in;
  logic        MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in, MemSigned_in;
  logic [1:0]  MemSize_in;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, MemToReg_out, RegWrite_out;
  logic        misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out;
  logic [3:0]  dmem_be;
  logic [4:0]  reg_dest_out;
  logic [1:0]  state_dbg;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .reg_dest_in(reg_dest_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .MemSize_in(MemSize_in), .MemSigned_in(MemSigned_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .mem_data_out(mem_data_out),
    .alu_result_out(alu_result_out), .reg_dest_out(reg_dest_out),
    .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
    .misalign_err(misalign_err), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [BW-1:0] bus_exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [RW-1:0] res(input logic [31:0] d, input logic rw,
                                        input logic mis, input logic be, input int st);
    return {d, rw, mis, be, 8'(st)};
  endfunction

  function automatic logic [BW-1:0] busv(input logic we, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [3:0] be);
    return {we, a, wd, be};
  endfunction

  // Monitor: a bus request is checked on its first cycle; a result is
  // checked in the cycle the stage lets the pipeline advance with an op.
  int   stall_cnt = 0;
  logic req_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      stall_cnt = 0;
      req_prev  = 1'b0;
    end else begin
      if (dmem_req && !req_prev) begin
        if (bus_exp_q.size() == 0) fail_now("unexpected_dmem_req");
        else check("bus_req", {dmem_we, dmem_addr, dmem_wdata, dmem_be}, bus_exp_q.pop_front());
      end
      req_prev = dmem_req;
      if (stall) stall_cnt++;
      else if (MemRead_in || MemWrite_in) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", {mem_data_out, RegWrite_out, misalign_err, bus_err, 8'(stall_cnt)},
                   exp_q.pop_front());
        stall_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic clear_ops();
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    MemToReg_in = 1'b0;
    RegWrite_in = 1'b0;
    dmem_ack    = 1'b0;
  endtask

  // Called #1 after a rising edge. k = cycle in ACCESS carrying the ack
  // (0 = never ack).
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                       input logic rw, input logic [31:0] rdata, input int k);
    int cycles;
    MemRead_in    = rd;
    MemWrite_in   = wr;
    MemToReg_in   = rd;
    RegWrite_in   = rw;
    MemSize_in    = size;
    MemSigned_in  = sgn;
    alu_result_in = addr;
    store_data_in = sd;
    reg_dest_in   = 5'd7;
    dmem_rdata    = rdata;
    #1;
    if (!stall) begin
      @(posedge clock); #1;
      clear_ops();
      return;
    end
    cycles = 0;
    forever begin
      @(posedge clock); #1;
      cycles++;
      if (!stall) begin
        dmem_ack = 1'b0;
        break;
      end
      if (cycles > 60) begin
        fail_now("access_never_completed");
        break;
      end
      dmem_ack = (cycles == k);
    end
    @(posedge clock); #1;
    clear_ops();
    @(posedge clock); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    clear_ops();
    alu_result_in = 32'h10; store_data_in = 32'h0; reg_dest_in = 5'd3;
    MemSize_in = 2'b10; MemSigned_in = 1'b0; dmem_rdata = 32'h0;
    // Hold a legal load during reset: stage must not stall or write back.
    MemRead_in = 1'b1; RegWrite_in = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_bus_outputs", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}, '0);
    check("reset_flags", {misalign_err, bus_err, stall, RegWrite_out}, '0);
    check("reset_data_state", {mem_data_out, state_dbg}, '0);
    check("reset_passthrough", {alu_result_out, reg_dest_out}, {32'h10, 5'd3});
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_ops();
    @(posedge clock); #1;

    // Word load, ack in first ACCESS cycle.
    bus_exp_q.push_back(busv(1'b0, 32'h10, 32'h0, 4'b1111));
    exp_q.push_back(res(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2));
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1);

    // Signed byte load, lane 3, ack in third ACCESS cycle.
    bus_exp_q.push_back(busv(1'b0, 32'h10, 32'h0, 4'b1111));
    exp_q.push_back(res(32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 4));
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 32'h80FF0011, 3);

    // Half store to upper half.
    bus_exp_q.push_back(busv(1'b1, 32'h20, 32'hABCDABCD, 4'b1100));
    exp_q.push_back(res(32'h0, 1'b0, 1'b0, 1'b0, 3));
    do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 1'b0, 32'h0, 2);

    // Misaligned word load: no bus, error pulse, write-back suppressed.
    exp_q.push_back(res(32'h0, 1'b0, 1'b1, 1'b0, 0));
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1);

    // Unsigned byte load, lane 1.
    bus_exp_q.push_back(busv(1'b0, 32'h10, 32'h0, 4'b1111));
    exp_q.push_back(res(32'h000000F6, 1'b1, 1'b0, 1'b0, 3));
    do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 32'h1234F6A5, 2);

    // Signed half load, upper half.
    bus_exp_q.push_back(busv(1'b0, 32'h10, 32'h0, 4'b1111));
    exp_q.push_back(res(32'hFFFF8001, 1'b1, 1'b0, 1'b0, 2));
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 32'h80017FFF, 1);

    // Unsigned half load, lower half.
    bus_exp_q.push_back(busv(1'b0, 32'h10, 32'h0, 4'b1111));
    exp_q.push_back(res(32'h0000F00D, 1'b1, 1'b0, 1'b0, 2));
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1, 32'h8001F00D, 1);

    // Signed byte load of a positive byte, lane 0.
    bus_exp_q.push_back(busv(1'b0, 32'h14, 32'h0, 4'b1111));
    exp_q.push_back(res(32'h0000007F, 1'b1, 1'b0, 1'b0, 2));
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 1'b1, 32'hFFFFFF7F, 1);

    // Byte store, lane 3.
    bus_exp_q.push_back(busv(1'b1, 32'h14, 32'hA5A5A5A5, 4'b1000));
    exp_q.push_back(res(32'h0, 1'b0, 1'b0, 1'b0, 2));
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h17, 32'h000000A5, 1'b0, 32'h0, 1);

    // Word store.
    bus_exp_q.push_back(busv(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111));
    exp_q.push_back(res(32'h0, 1'b0, 1'b0, 1'b0, 3));
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0, 2);

    // Illegal: size 11, read+write together, odd half address.
    exp_q.push_back(res(32'h0, 1'b0, 1'b1, 1'b0, 0));
    do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 1);
    exp_q.push_back(res(32'h0, 1'b0, 1'b1, 1'b0, 0));
    do_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 1);
    exp_q.push_back(res(32'h0, 1'b0, 1'b1, 1'b0, 0));
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 1'b1, 32'h0, 1);
    @(posedge clock); #1;

    // Reset mid-ACCESS, then a stale ack that must be ignored.
    bus_exp_q.push_back(busv(1'b0, 32'h10, 32'h0, 4'b1111));
    MemRead_in = 1'b1; MemToReg_in = 1'b1; RegWrite_in = 1'b1;
    MemSize_in = 2'b10; alu_result_in = 32'h10; dmem_rdata = 32'h55AA55AA;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    clear_ops();
    @(posedge clock); #1;
    reset_n  = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clock);
    check("post_reset_req_state", {dmem_req, state_dbg, stall}, '0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    @(negedge clock);
    check("stale_ack_ignored", {dmem_req, state_dbg, mem_data_out}, '0);
    @(posedge clock); #1;

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 ACCESS cycles.
    bus_exp_q.push_back(busv(1'b0, 32'h80, 32'h0, 4'b1111));
    exp_q.push_back(res(32'h0, 1'b0, 1'b0, 1'b1, 5));
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0BADF00D, 0);
    // Ack on the limit cycle completes normally.
    bus_exp_q.push_back(busv(1'b0, 32'h80, 32'h0, 4'b1111));
    exp_q.push_back(res(32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5));
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0BADF00D, 4);
`else
    // Long-latency ack: ACCESS waits, no bus error.
    bus_exp_q.push_back(busv(1'b0, 32'h80, 32'h0, 4'b1111));
    exp_q.push_back(res(32'h0BADF00D, 1'b1, 1'b0, 1'b0, 11));
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0BADF00D, 10);
`endif

    repeat (3) @(posedge clock);
    check("result_queue_drained", 69'(exp_q.size()), 69'd0);
    check("bus_queue_drained", 69'(bus_exp_q.size()), 69'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
